// File: rtl/cdc_handshake_tx_pkg.sv
// Shared types and helpers for the toggle req/ack CDC source controller.
// Optional timeout feature in the top is guarded by CDC_TX_TIMEOUT_EN.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } hs_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    // Minimum width of 1 so single-entry counters and indices stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Requester and crossing signals of the CDC source controller.
// The master modport is the controller's view; slave is the environment's.
interface cdc_handshake_tx_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_grant;
    logic [NREQ-1:0]       req_done;
    logic [WIDTH-1:0]      xfer_data;
    logic                  xfer_req;
    logic                  xfer_ack_sync;
    logic                  busy;
    logic                  err;
    logic                  err_clr;

    modport master (
        input  req_valid, req_data, xfer_ack_sync, err_clr,
        output req_grant, req_done, xfer_data, xfer_req, busy, err
    );

    modport slave (
        output req_valid, req_data, xfer_ack_sync, err_clr,
        input  req_grant, req_done, xfer_data, xfer_req, busy, err
    );
endinterface

// File: rtl/cdc_handshake_tx_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
    import cdc_hs_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]        grant,
    output logic [clog2(NREQ)-1:0] idx
);
    localparam int unsigned IW = clog2(NREQ);

    always_comb begin
        int unsigned cand;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack bundled-data crossing with round-robin requesters.
// Define CDC_TX_TIMEOUT_EN to add the WAIT_ACK timeout and sticky err flag.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic               clk,
    input logic               arst_n,
    cdc_handshake_tx_if.master bus
);
    localparam int unsigned IW = clog2(NREQ);

    hs_state_t       state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   ptr_next;
    logic            quiescent;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign quiescent = (bus.xfer_ack_sync == bus.xfer_req);
    assign ptr_next  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CW = clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= IDLE;
            idx           <= '0;
            ptr           <= '0;
            bus.xfer_data <= '0;
            bus.xfer_req  <= 1'b0;
            bus.req_grant <= '0;
            bus.req_done  <= '0;
            bus.busy      <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            tmo_cnt       <= '0;
            bus.err       <= 1'b0;
`endif
        end else begin
            bus.req_grant <= '0;
            bus.req_done  <= '0;
`ifdef CDC_TX_TIMEOUT_EN
            // Clear first so a timeout later in this block wins.
            if (bus.err_clr) begin
                bus.err <= 1'b0;
            end
`endif
            unique case (state)
                IDLE: begin
                    if ((|bus.req_valid) && quiescent) begin
                        bus.xfer_data <= bus.req_data[int'(arb_idx)*WIDTH +: WIDTH];
                        idx           <= arb_idx;
                        bus.req_grant <= arb_grant;
                        bus.busy      <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.xfer_req <= ~bus.xfer_req;
`ifdef CDC_TX_TIMEOUT_EN
                    tmo_cnt      <= '0;
`endif
                    state        <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (quiescent) begin
                        bus.req_done <= NREQ'(1) << idx;
                        ptr          <= ptr_next;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
`ifdef CDC_TX_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus.err      <= 1'b1;
                        bus.req_done <= NREQ'(1) << idx;
                        ptr          <= ptr_next;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx with a 3-stage ack loopback model.
// Exercises the timeout path when built with CDC_TX_TIMEOUT_EN, the stuck-ack path otherwise.
module tb_cdc_handshake_tx;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    cdc_handshake_tx #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    logic [2:0] ack_pipe;
    logic       ack_override;
    logic       ack_force;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) ack_pipe <= '0;
        else         ack_pipe <= {ack_pipe[1:0], bus.xfer_req};
    end
    assign bus.xfer_ack_sync = ack_override ? ack_force : ack_pipe[2];

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        grant_q[$];
    int          done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_ptr;
    logic        exp_req;
    logic        in_xfer = 1'b0;
    logic [15:0] held;
    exp_t        mon_e;
    int          mon_d;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_xfer(input int i, input logic [15:0] d, input logic with_done);
        exp_t e;
        e.idx  = i;
        e.data = d;
        grant_q.push_back(e);
        if (with_done) done_q.push_back(i);
    endtask

    function automatic int model_pick(input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (bus.req_grant != '0) return;
            step();
        end
        check_eq(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (bus.req_done != '0) return;
            step();
        end
        check_eq(tag, 64'd0, 64'd1);
    endtask

    // Monitor: samples outputs at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!arst_n) begin
            in_xfer = 1'b0;
        end else begin
            if (in_xfer) check_eq("data_stable", 64'(bus.xfer_data), 64'(held));
            if (bus.req_grant != '0) begin
                if (grant_q.size() == 0) begin
                    check_eq("grant_unexpected", 64'(bus.req_grant), 64'd0);
                end else begin
                    mon_e = grant_q.pop_front();
                    check_eq("grant_onehot", 64'(bus.req_grant), 64'd1 << mon_e.idx);
                    check_eq("grant_data", 64'(bus.xfer_data), 64'(mon_e.data));
                end
                held    = bus.xfer_data;
                in_xfer = 1'b1;
            end
            if (bus.req_done != '0) begin
                if (done_q.size() == 0) begin
                    check_eq("done_unexpected", 64'(bus.req_done), 64'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    check_eq("done_onehot", 64'(bus.req_done), 64'd1 << mon_d);
                end
                in_xfer = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {bus.req_grant, bus.req_done, bus.xfer_data, bus.xfer_req, bus.busy, bus.err},
                 64'd0);
    endtask

    initial begin
        logic [3:0]  v;
        logic [15:0] d;
        int          c;
        int          k;

        arst_n        = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.err_clr   = 1'b0;
        ack_override  = 1'b0;
        ack_force     = 1'b0;
        model_ptr     = 0;
        exp_req       = 1'b0;
        step();
        step();
        check_reset_outputs("reset_state");
        arst_n = 1'b1;
        step();

        // Single transfer from requester 1
        bus.req_data[16 +: 16] = 16'hA5A5;
        bus.req_valid = 4'b0010;
        push_xfer(1, 16'hA5A5, 1'b1);
        step();
        check_eq("single_grant_cycle1", 64'(bus.req_grant), 64'h2);
        check_eq("single_busy", 64'(bus.busy), 64'd1);
        bus.req_valid = '0;
        bus.req_data  = '1;
        step();
        check_eq("single_req_toggle", 64'(bus.xfer_req), 64'd1);
        exp_req = 1'b1;
        k = 0;
        while (bus.xfer_ack_sync != 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_eq("single_ack_seen", 64'(bus.xfer_ack_sync), 64'd1);
        step();
        check_eq("single_done_after_ack", 64'(bus.req_done), 64'h2);
        step();
        check_eq("single_busy_low", 64'(bus.busy), 64'd0);
        model_ptr = 2;

        // Round robin with all requesters asserted, from a fresh pointer
        arst_n = 1'b0;
        step();
        check_reset_outputs("reset_idle");
        arst_n    = 1'b1;
        model_ptr = 0;
        exp_req   = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*16 +: 16] = 16'hC0D0 + 16'(i) * 16'h1111;
        v = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            c = model_pick(v);
            d = bus.req_data[c*16 +: 16];
            push_xfer(c, d, 1'b1);
            model_ptr = (c + 1) % NREQ;
            exp_req   = ~exp_req;
        end
        bus.req_valid = v;
        k = 0;
        while (done_q.size() != 0 && k < 200) begin
            step();
            if (grant_q.size() == 0) bus.req_valid = '0;
            k++;
        end
        check_eq("rr_drained", 64'(done_q.size()), 64'd0);
        check_eq("rr_req_level", 64'(bus.xfer_req), 64'(exp_req));

        // Data stability while requester data churns
        v = 4'b0100;
        d = 16'($urandom);
        bus.req_data[2*16 +: 16] = d;
        push_xfer(model_pick(v), d, 1'b1);
        model_ptr = 3;
        exp_req   = ~exp_req;
        bus.req_valid = v;
        wait_grant("stab_grant_timeout");
        bus.req_valid = '0;
        for (int i = 0; i < 30; i++) begin
            if (bus.req_done != '0) break;
            bus.req_data = {$urandom, $urandom};
            step();
        end
        check_eq("stab_done_seen", 64'(bus.req_done != '0), 64'd1);
        check_eq("stab_req_level", 64'(bus.xfer_req), 64'(exp_req));

        // Reset during WAIT_ACK, then ack stuck high after reset
        ack_override = 1'b1;
        ack_force    = exp_req;
        d = 16'h3C3C;
        bus.req_data[3*16 +: 16] = d;
        push_xfer(3, d, 1'b0);
        bus.req_valid = 4'b1000;
        wait_grant("mid_grant_timeout");
        bus.req_valid = '0;
        step();
        step();
        check_eq("mid_busy", 64'(bus.busy), 64'd1);
        arst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        ack_force = 1'b1;
        step();
        arst_n    = 1'b1;
        model_ptr = 0;
        exp_req   = 1'b0;
        bus.req_data[15:0] = 16'h5A5A;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("blocked_after_reset", {60'd0, bus.busy, bus.req_grant[2:0]} | 64'(bus.req_grant[3]) << 3,
                     64'd0);
        end
        push_xfer(0, 16'h5A5A, 1'b1);
        ack_force = 1'b0;
        wait_grant("post_reset_grant_timeout");
        bus.req_valid = '0;
        ack_override  = 1'b0;
        model_ptr = 1;
        exp_req   = 1'b1;
        wait_done("post_reset_done_timeout");
        step();

`ifdef CDC_TX_TIMEOUT_EN
        // Stuck ack: timeout after TMO WAIT_ACK cycles, err_clr held to show set wins
        ack_override = 1'b1;
        ack_force    = exp_req;
        d = 16'hBEEF;
        bus.req_data[16 +: 16] = d;
        push_xfer(model_pick(4'b0010), d, 1'b1);
        model_ptr = 2;
        exp_req   = ~exp_req;
        bus.req_valid = 4'b0010;
        wait_grant("tmo_grant_timeout");
        bus.req_valid = '0;
        bus.err_clr   = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            k = i;
            if (bus.req_done != '0) break;
        end
        check_eq("tmo_cycles", 64'(k), 64'(TMO + 1));
        check_eq("tmo_err_set_wins", 64'(bus.err), 64'd1);
        bus.err_clr = 1'b0;
        bus.req_data[2*16 +: 16] = 16'h7E57;
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("tmo_blocked", {bus.err, bus.busy, bus.req_grant}, 6'b100000);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check_eq("tmo_err_clr", 64'(bus.err), 64'd0);
        push_xfer(model_pick(4'b0100), 16'h7E57, 1'b1);
        model_ptr = 3;
        ack_force = exp_req;
        exp_req   = ~exp_req;
        wait_grant("tmo_regrant_timeout");
        bus.req_valid = '0;
        ack_override  = 1'b0;
        wait_done("tmo_redone_timeout");
        check_eq("tmo_req_level", 64'(bus.xfer_req), 64'(exp_req));
`else
        // Stuck ack without timeout: busy holds, err never rises, err_clr ignored
        ack_override = 1'b1;
        ack_force    = exp_req;
        d = 16'hBEEF;
        bus.req_data[16 +: 16] = d;
        push_xfer(model_pick(4'b0010), d, 1'b1);
        model_ptr = 2;
        exp_req   = ~exp_req;
        bus.req_valid = 4'b0010;
        wait_grant("stuck_grant_timeout");
        bus.req_valid = '0;
        bus.err_clr   = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            step();
            check_eq("stuck_busy_err", {bus.busy, bus.err, bus.req_done}, 6'b100000);
        end
        bus.err_clr  = 1'b0;
        ack_override = 1'b0;
        wait_done("stuck_release_timeout");
        check_eq("stuck_req_level", 64'(bus.xfer_req), 64'(exp_req));
`endif

        step();
        step();
        check_eq("queues_empty", 64'(grant_q.size() + done_q.size()), 64'd0);
        check_eq("final_idle", 64'(bus.busy), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-side controller for a toggle req/ack bundled-data clock-domain crossing.
- Arbitrates round-robin between NREQ requesters in the clk domain and latches the winner's word into a stable hold register.
- Toggles xfer_req, which travels through an external synchronizer instance into the destination domain.
- Completes the transfer when the destination's ack toggle, returned through another external synchronizer, matches xfer_req.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 16: data word width.
- TIMEOUT_CYCLES, 1024: WAIT_ACK cycle limit; only used with CDC_TX_TIMEOUT_EN.

Ports:
- clk  in  1  single clock.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester transfer request.
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_grant  out  NREQ  one-hot, 1-cycle pulse when requester i's word is captured.
- req_done  out  NREQ  one-hot, 1-cycle pulse when requester i's transfer is acknowledged.
- xfer_data  out  WIDTH  hold register driven to the destination domain.
- xfer_req  out  1  request toggle, fed to the external synchronizer.
- xfer_ack_sync  in  1  ack toggle, already synchronized into clk.
- busy  out  1  high when the FSM is not in IDLE.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset values (asynchronous, arst_n=0): xfer_data=0, xfer_req=0, req_grant=0, req_done=0, busy=0, err=0, rr pointer=0, FSM=IDLE, timeout counter=0.
- The channel is quiescent when xfer_ack_sync==xfer_req. No transfer is started unless the channel is quiescent.
- IDLE:
  - Condition: any req_valid set and channel quiescent.
  - Winner: the first set bit at or above the rr pointer, wrapping modulo NREQ.
  - Action: latch req_data of the winner into xfer_data, store its index, pulse req_grant[idx], go to LAUNCH.
  - A requester may drop valid or change data from the cycle after its grant.
- LAUNCH (exactly 1 cycle): xfer_data is held stable for one cycle of setup, then xfer_req is inverted. Go to WAIT_ACK.
- WAIT_ACK:
  - Wait until xfer_ack_sync==xfer_req.
  - Then pulse req_done[idx], set rr pointer = (idx+1) mod NREQ, go to IDLE.
  - xfer_data and xfer_req are held unchanged throughout WAIT_ACK.
- Latency: valid sampled at edge 0 gives grant in cycle 1 and the xfer_req toggle at edge 2. Done follows 1 cycle after the ack match is seen.
- Back-to-back: the earliest next grant is the cycle after done.
- Arbitration timing: the rr pointer updates only on done. Requests arriving during busy wait and are not queued elsewhere.
- Simultaneous valid from all requesters: each is serviced once per NREQ transfers, in pointer order.
- Reset mid-operation: all state returns to reset values. The destination domain is reset in the same event, so the ack returns to 0.
  - If xfer_ack_sync≠0 after reset, the FSM stays in IDLE (not quiescent) until the two match. No grant is issued meanwhile.
- err_clr and the timeout setting err in the same cycle: set wins.
- xfer_data is never a synchronized bus. Its multicycle path is guaranteed by LAUNCH plus the synchronizer depth.

Optional Feature:
- Macro: CDC_TX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - On reaching TIMEOUT_CYCLES-1 without a match: set err, pulse req_done[idx], advance the pointer, go to IDLE.
  - The channel then remains blocked until xfer_ack_sync==xfer_req.
  - err_clr clears err.
- Undefined: no counter exists, err is tied to 0, err_clr is ignored, and WAIT_ACK waits indefinitely.

Decomposition:
- Package cdc_hs_pkg holds:
  - State encoding typedef (IDLE, LAUNCH, WAIT_ACK).
  - Default TIMEOUT_CYCLES constant.
  - Function clog2 for the index/counter widths.
- Sub-module: rr_arbiter (NREQ param).
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and binary index.
  - Purely combinational, so the priority logic is testable in isolation.

Test Plan:
- Single transfer: req_valid=4'b0010 with data 16'hA5A5, ack looped back through a 3-stage delay.
  - grant[1] in cycle 1, xfer_data=A5A5, xfer_req 0→1 at edge 2.
  - done[1] 1 cycle after ack_sync=1, busy low the following cycle.
- Round robin: req_valid=4'b1111 held high.
  - Grants in order 0,1,2,3,0.
  - Each requester's data appears on xfer_data exactly once per cycle of four.
- Stuck ack with CDC_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: ack held at 0.
  - err=1 and done pulse after 16 WAIT_ACK cycles.
  - No further grant until ack is forced to 1. err_clr clears err.
- Reset mid-transfer: assert arst_n=0 during WAIT_ACK.
  - All outputs at reset values immediately.
  - With ack_sync held at 1 after reset, no grant occurs until ack_sync returns to 0.
- Data stability: randomize req_data every cycle after the grant.
  - xfer_data stays constant from the grant until done.
- Build without the macro, ack stuck for 5000 cycles: err stays 0 and busy stays 1.
